// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch-to-decode instruction queue with flush and zero bubble when empty
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic push, pop;
  always_comb begin
    if_ready = rst && (cnt != CNT_W'(DEPTH));
    id_valid = cnt != '0;
    id_pc    = id_valid ? pc_mem[rd_ptr] : '0;
    id_inst  = id_valid ? inst_mem[rd_ptr] : '0;
    count    = cnt;
    push     = if_valid && if_ready && !flush;
    pop      = id_valid && id_ready && !flush;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end
  always_ff @(posedge clk) if (rst) assert (cnt <= CNT_W'(DEPTH));
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised fetch-to-decode decoupling stage. It replaces the single-entry IF/ID pipeline register with a DEPTH-entry instruction queue.
- Fetch pushes (pc, inst) pairs with a valid/ready handshake. Decode pops them with a valid/ready handshake.
- A flush input discards all queued instructions on a branch redirect or exception.
- Whenever the queue is empty, decode sees a zero bubble (pc=0, inst=0), the same as a stalled or flushed single register.

Parameters:
ADDR_W, 32, width of instruction address
INST_W, 32, width of instruction word
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets on the clock edge)
flush  input  1  discard all entries (branch redirect / exception)
if_valid  input  1  fetch presents an instruction
if_pc  input  ADDR_W  fetch instruction address
if_inst  input  INST_W  fetch instruction word
if_ready  output  1  queue accepts a push this cycle
id_ready  input  1  decode consumes head this cycle (0 = decode stalled)
id_valid  output  1  head entry valid
id_pc  output  ADDR_W  head address; zero when id_valid=0
id_inst  output  INST_W  head instruction; zero when id_valid=0
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- State:
  - storage array of DEPTH entries {pc, inst}
  - read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count register, CNT_W bits
- Reset (rst==0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Storage contents are don't-care but must never be visible on the outputs.
  - Outputs during reset and the first cycle after: id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=0 while rst==0.
- Combinational outputs (all derived from registered state):
  - if_ready = rst && (count != DEPTH). There is no full-queue pass-through: when full, if_ready=0 even if id_ready=1.
  - id_valid = (count != 0).
  - id_pc / id_inst = storage[rd_ptr] when id_valid, else 0.
  - count port = count register.
- Events:
  - push = if_valid && if_ready && !flush
  - pop = id_valid && id_ready && !flush
- Priority per clock edge: reset > flush > push/pop.
- Flush:
  - Sets rd_ptr=0, wr_ptr=0, count=0.
  - A push offered in the flush cycle is discarded.
  - A pop in the flush cycle is not counted.
  - id_valid=0 from the next cycle.
- Push: storage[wr_ptr] <= {if_pc, if_inst}; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments, wrapping DEPTH-1 -> 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Simultaneous push and pop:
  - Legal at any occupancy 1..DEPTH-1.
  - At count==DEPTH push is impossible (if_ready=0); a pop frees a slot visible next cycle.
  - At count==0 pop is impossible; there is no bypass.
- Latency: an entry pushed at edge N is visible on id_* after edge N; minimum fetch-to-decode latency is 1 cycle, the same as the single register.
- Ordering: strict FIFO. Entries are popped in push order across pointer wrap-around.
- Stall (id_ready=0):
  - Head and all outputs hold exactly.
  - Pushes continue until full.
- Bubble: when the queue is empty, decode sees pc=0, inst=0, id_valid=0 (a nop).
- Reset mid-operation: any queued entries are discarded identically to flush. A push or pop in that cycle is ignored.
- Overflow/underflow are impossible by construction. An assertion checks that count never exceeds DEPTH.

Test Plan:
- Reset hold: rst=0 for 3 cycles with if_valid=1, if_pc=0x100, if_inst=0x24010001 -> count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=0 throughout; if_ready=1 on the first cycle with rst=1.
- Streaming: id_ready=1, push pc 0x0,0x4,0x8,... one per cycle -> each pc appears on id_pc exactly 1 cycle after its push; count stays 1; no gaps.
- Fill and stall: id_ready=0, push 5 instructions with DEPTH=4 -> pushes 0x0..0xC accepted, count=4, if_ready=0 on the 5th; id_pc holds 0x0. Raise id_ready -> outputs 0x0,0x4,0x8,0xC in order, then the 5th after if_ready reasserts.
- Wrap-around: interleave so that wr_ptr wraps twice (12 pushes, mixed stalls) -> pop order matches push order exactly; count tracks the reference model each cycle.
- Flush: count=3, assert flush with if_valid=1 (pc 0x200) and id_ready=1 -> next cycle count=0, id_valid=0, id_pc=0; 0x200 is not enqueued; the next push 0x300 appears 1 cycle later.
- Full simultaneous: count=4, id_ready=1, if_valid=1 -> pop only, count=3, if_ready=1 next cycle; then push+pop together -> count stays 3.
